// File: rtl/serial_adder_pkg.sv
// Purpose: shared FSM state type and default operand width for the serial adder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_adder_pkg;

   localparam int WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_fa.sv
// Purpose: one-bit full adder used as the per-bit adder of the serial datapath.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no state and no handshake.
module fullAdder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule : fullAdder

// File: rtl/serial_adder.sv
// Purpose: bit-serial unsigned adder, opA+opB+carryIn, one bit pair per cycle LSB first.
// Latency: outValid rises WIDTH cycles after the accepting edge; issue interval WIDTH+2 cycles.
// Backpressure: result held stable in DONE until outReady; inReady low outside IDLE.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inValid,
   output logic             inReady,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   input  logic             carryIn,
   output logic             outValid,
   input  logic             outReady,
   output logic [WIDTH-1:0] sum,
   output logic             carryOut
);

   // Counter needs at least one bit even for the narrowest legal width.
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           state;
   state_t           next_state;
   logic             load;
   logic             step;

   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] sum_reg;
   logic             carry_reg;
   logic [CW-1:0]    cnt;

   logic             fa_sum;
   logic             fa_carry;

   // The only arithmetic: LSBs of the shifting operands plus the running carry.
   fullAdder u_fa (
      .a  (a_reg[0]),
      .b  (b_reg[0]),
      .ci (carry_reg),
      .s  (fa_sum),
      .co (fa_carry)
   );

   // State register; reset forces IDLE immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode plus handshake outputs and datapath controls.
   always_comb begin
      next_state = state;
      load       = 1'b0;
      step       = 1'b0;
      inReady    = 1'b0;
      outValid   = 1'b0;
      case (state)
         IDLE: begin
            inReady = 1'b1;
            if (inValid) begin
               load       = 1'b1;
               next_state = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (cnt == LAST_BIT) begin
               next_state = DONE;
            end
         end
         DONE: begin
            outValid = 1'b1;
            if (outReady) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Datapath: load operands on accept, then shift one bit pair per RUN cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg     <= '0;
         b_reg     <= '0;
         sum_reg   <= '0;
         carry_reg <= 1'b0;
         cnt       <= '0;
      end else if (load) begin
         a_reg     <= opA;
         b_reg     <= opB;
         carry_reg <= carryIn;
         cnt       <= '0;
      end else if (step) begin
         a_reg     <= a_reg >> 1;
         b_reg     <= b_reg >> 1;
         carry_reg <= fa_carry;
         // Sum bits enter at the MSB so the first (LSB) result ends up at bit 0.
         sum_reg   <= {fa_sum, sum_reg[WIDTH-1:1]};
         // Hold at the last index rather than wrapping when WIDTH is a power of two.
         if (cnt != LAST_BIT) begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   // Outside RUN the carry register holds the final carry, so it doubles as carryOut.
   assign sum      = sum_reg;
   assign carryOut = carry_reg;

endmodule : serial_adder
